// File: rtl/fifo_uart_tx_if.sv
// Handshake bundle between the upstream FIFO / line side and the UART transmitter.
// The slave modport is the transmitter's view; master is the FIFO/line side.
interface fifo_uart_tx_if #(
  parameter int BIT_D = 8
);
  logic             en_i;
  logic             fifo_empty_i;
  logic [BIT_D-1:0] fifo_data_i;
  logic             fifo_rd_o;
  logic             tx_o;
  logic             busy_o;
  logic [7:0]       frame_cnt_o;

  modport slave (
    input  en_i,
    input  fifo_empty_i,
    input  fifo_data_i,
    output fifo_rd_o,
    output tx_o,
    output busy_o,
    output frame_cnt_o
  );

  modport master (
    output en_i,
    output fifo_empty_i,
    output fifo_data_i,
    input  fifo_rd_o,
    input  tx_o,
    input  busy_o,
    input  frame_cnt_o
  );
endinterface

// File: rtl/fifo_uart_tx.sv
// UART transmitter that pops words from an upstream FIFO and sends them as
// start / BIT_D data bits (LSB first) / stop frames, CLK_DIV clocks per bit.
module fifo_uart_tx #(
  parameter int CLK_DIV = 16,
  parameter int BIT_D   = 8
) (
  input  logic          clk_i,
  input  logic          srst_i,
  fifo_uart_tx_if.slave bus
);

  localparam int CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int IDX_W = (BIT_D > 1) ? $clog2(BIT_D) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLK_DIV - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(BIT_D - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_POP   = 3'd1,
    S_LOAD  = 3'd2,
    S_START = 3'd3,
    S_DATA  = 3'd4,
    S_STOP  = 3'd5
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [BIT_D-1:0] shreg_q, shreg_d;
  logic [7:0]       frame_q, frame_d;
  logic             tx_q, tx_d;
  logic             rd_q, rd_d;
  logic             busy_q, busy_d;

  // State register and registered outputs; srst_i wins over everything.
  always_ff @(posedge clk_i) begin
    if (srst_i) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      shreg_q <= '0;
      frame_q <= 8'd0;
      tx_q    <= 1'b1;
      rd_q    <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shreg_q <= shreg_d;
      frame_q <= frame_d;
      tx_q    <= tx_d;
      rd_q    <= rd_d;
      busy_q  <= busy_d;
    end
  end

  // Next-state logic; outputs are decoded from the next state so they line up with state_q.
  always_comb begin
    state_d = state_q;
    cnt_d   = '0;
    idx_d   = idx_q;
    shreg_d = shreg_q;
    frame_d = frame_q;
    tx_d    = 1'b1;
    rd_d    = 1'b0;
    busy_d  = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (bus.en_i && !bus.fifo_empty_i) begin
          state_d = S_POP;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_POP: begin
        state_d = S_LOAD;
      end
      S_LOAD: begin
        shreg_d = bus.fifo_data_i;
        state_d = S_START;
      end
      S_START: begin
        if (cnt_q == CNT_LAST) begin
          state_d = S_DATA;
          idx_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_DATA: begin
        if (cnt_q == CNT_LAST) begin
          if (idx_q == IDX_LAST) begin
            state_d = S_STOP;
            idx_d   = '0;
          end else begin
            idx_d   = idx_q + IDX_W'(1);
            shreg_d = shreg_q >> 1;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_STOP: begin
        if (cnt_q == CNT_LAST) begin
          state_d = S_IDLE;
          frame_d = frame_q + 8'd1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    rd_d   = (state_d == S_POP);
    busy_d = (state_d != S_IDLE);
    case (state_d)
      S_START: tx_d = 1'b0;
      S_DATA:  tx_d = shreg_d[0];
      default: tx_d = 1'b1;
    endcase
  end

  assign bus.fifo_rd_o   = rd_q;
  assign bus.tx_o        = tx_q;
  assign bus.busy_o      = busy_q;
  assign bus.frame_cnt_o = frame_q;

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Directed bench for fifo_uart_tx (CLK_DIV=4, BIT_D=8): emulated FIFO, a
// frame-position model checked every cycle, and hand-computed scenario checks.
module tb_fifo_uart_tx;

  localparam int CD    = 4;
  localparam int BD    = 8;
  localparam int FRAME = 2 + (BD + 2) * CD;

  logic clk  = 1'b0;
  logic srst = 1'b1;

  fifo_uart_tx_if #(.BIT_D(BD)) bus ();

  fifo_uart_tx #(.CLK_DIV(CD), .BIT_D(BD)) dut (
    .clk_i  (clk),
    .srst_i (srst),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  // Upstream FIFO emulation: data appears the cycle after a pop.
  logic [7:0] mem [0:511];
  int         wr_cnt = 0;
  int         rd_ptr = 0;
  logic [7:0] fifo_data_q = 8'h00;

  assign bus.fifo_empty_i = (rd_ptr == wr_cnt);
  assign bus.fifo_data_i  = fifo_data_q;

  always @(posedge clk) begin
    if (bus.fifo_rd_o === 1'b1) begin
      fifo_data_q <= mem[rd_ptr[8:0]];
      rd_ptr      <= rd_ptr + 1;
    end
  end

  // Model: a transaction is FRAME cycles long (pop, load, then 10 bit slots).
  logic       m_act    = 1'b0;
  int         m_pos    = 0;
  int         m_idx    = 0;
  logic [7:0] m_word   = 8'h00;
  logic [7:0] m_frames = 8'h00;

  always @(posedge clk) begin
    if (srst) begin
      m_act    <= 1'b0;
      m_pos    <= 0;
      m_frames <= 8'h00;
    end else if (!m_act) begin
      if (bus.en_i && (m_idx != wr_cnt)) begin
        m_act  <= 1'b1;
        m_pos  <= 0;
        m_word <= mem[m_idx[8:0]];
        m_idx  <= m_idx + 1;
      end
    end else if (m_pos == FRAME - 1) begin
      m_act    <= 1'b0;
      m_frames <= m_frames + 8'd1;
    end else begin
      m_pos <= m_pos + 1;
    end
  end

  function automatic logic exp_tx();
    int         k;
    logic [7:0] w;
    if (!m_act || m_pos < 2) return 1'b1;
    k = (m_pos - 2) / CD;
    if (k == 0) return 1'b0;
    if (k > BD) return 1'b1;
    w = m_word >> (k - 1);
    return w[0];
  endfunction

  int   n_cmp   = 0;
  int   n_fail  = 0;
  int   cyc     = 0;
  logic chk_on  = 1'b0;
  logic prev_busy = 1'b0;
  int   nrise   = 0;
  int   rise [0:7];
  logic seen255 = 1'b0;
  int   rd0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    cyc++;
    if (chk_on) begin
      check("model_tx",        32'(bus.tx_o),        32'(exp_tx()));
      check("model_fifo_rd",   32'(bus.fifo_rd_o),   32'(m_act && (m_pos == 0)));
      check("model_busy",      32'(bus.busy_o),      32'(m_act));
      check("model_frame_cnt", 32'(bus.frame_cnt_o), 32'(m_frames));
    end
    if (bus.busy_o === 1'b1 && prev_busy === 1'b0) begin
      if (nrise < 8) rise[nrise] = cyc;
      nrise++;
    end
    prev_busy = bus.busy_o;
    if (bus.frame_cnt_o === 8'hFF) seen255 = 1'b1;
  endtask

  task automatic push(input logic [7:0] d);
    mem[wr_cnt[8:0]] = d;
    wr_cnt++;
  endtask

  task automatic wait_tx_low(input int max, input string name);
    int n = 0;
    while (bus.tx_o !== 1'b0 && n < max) begin
      tick();
      n++;
    end
    check(name, 32'(bus.tx_o), 32'd0);
  endtask

  task automatic wait_busy(input logic val, input int max, input string name);
    int n = 0;
    while (bus.busy_o !== val && n < max) begin
      tick();
      n++;
    end
    check(name, 32'(bus.busy_o), 32'(val));
  endtask

  task automatic wait_drain(input int max, input string name);
    int n = 0;
    while (!(bus.busy_o === 1'b0 && rd_ptr == wr_cnt) && n < max) begin
      tick();
      n++;
    end
    check(name, 32'(n < max), 32'd1);
  endtask

  logic [9:0] a5_bits;

  initial begin
    a5_bits    = 10'b11_0100_1010;
    bus.en_i   = 1'b0;
    srst       = 1'b1;
    chk_on     = 1'b1;
    repeat (3) tick();
    check("reset_tx",        32'(bus.tx_o),        32'd1);
    check("reset_busy",      32'(bus.busy_o),      32'd0);
    check("reset_fifo_rd",   32'(bus.fifo_rd_o),   32'd0);
    check("reset_frame_cnt", 32'(bus.frame_cnt_o), 32'd0);
    srst = 1'b0;

    // Empty FIFO with enable held: nothing may happen.
    bus.en_i = 1'b1;
    repeat (100) tick();
    check("empty_no_pop", 32'(rd_ptr),      32'd0);
    check("empty_tx",     32'(bus.tx_o),    32'd1);
    check("empty_busy",   32'(bus.busy_o),  32'd0);

    // Single 0xA5 frame, sampled once per bit slot.
    push(8'hA5);
    wait_tx_low(10, "a5_start");
    for (int k = 0; k < 10; k++) begin
      check("a5_bit", 32'(bus.tx_o), 32'(a5_bits[k]));
      repeat (CD) tick();
    end
    check("a5_frame_cnt", 32'(bus.frame_cnt_o), 32'd1);
    check("a5_busy_done", 32'(bus.busy_o),      32'd0);
    check("a5_one_pop",   32'(rd_ptr),          32'd1);

    // Three back-to-back words: POP-to-POP spacing is 40 + 3 cycles.
    srst = 1'b1;
    tick();
    srst  = 1'b0;
    nrise = 0;
    push(8'h00);
    push(8'hFF);
    push(8'h3C);
    wait_drain(300, "b2b_drain");
    check("b2b_frames",    32'(nrise),             32'd3);
    check("b2b_spacing_1", 32'(rise[1] - rise[0]), 32'd43);
    check("b2b_spacing_2", 32'(rise[2] - rise[1]), 32'd43);
    check("b2b_frame_cnt", 32'(bus.frame_cnt_o),   32'd3);

    // Enable dropped mid-DATA: current frame finishes, nothing more popped.
    rd0 = rd_ptr;
    push(8'h11);
    push(8'h22);
    push(8'h33);
    wait_busy(1'b1, 10, "en_drop_start");
    repeat (20) tick();
    bus.en_i = 1'b0;
    wait_busy(1'b0, 60, "en_drop_finish");
    check("en_drop_pops",      32'(rd_ptr - rd0),      32'd1);
    check("en_drop_frame_cnt", 32'(bus.frame_cnt_o),   32'd4);
    repeat (20) tick();
    check("en_drop_idle_busy", 32'(bus.busy_o),        32'd0);
    check("en_drop_no_pop",    32'(rd_ptr - rd0),      32'd1);

    // Reset during data bit 3 aborts the frame; the next word starts cleanly.
    bus.en_i = 1'b1;
    wait_tx_low(10, "abort_start");
    repeat (17) tick();
    srst = 1'b1;
    tick();
    check("abort_tx",        32'(bus.tx_o),        32'd1);
    check("abort_busy",      32'(bus.busy_o),      32'd0);
    check("abort_frame_cnt", 32'(bus.frame_cnt_o), 32'd0);
    srst = 1'b0;
    tick();
    check("abort_restart_pop", 32'(bus.fifo_rd_o), 32'd1);
    wait_drain(100, "abort_drain");
    check("abort_after_cnt", 32'(bus.frame_cnt_o), 32'd1);

    // 256 frames: counter passes 255 and wraps to 0.
    srst = 1'b1;
    tick();
    srst    = 1'b0;
    seen255 = 1'b0;
    rd0     = rd_ptr;
    for (int i = 0; i < 256; i++) push(8'(i * 37));
    wait_drain(256 * 43 + 100, "wrap_drain");
    check("wrap_seen_255", 32'(seen255),          32'd1);
    check("wrap_frame_cnt", 32'(bus.frame_cnt_o), 32'd0);
    check("wrap_pops",     32'(rd_ptr - rd0),     32'd256);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
